// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use stall unit fed by ID-stage decode fields.
// Define FWD_STALL_COUNTER_EN to add the saturating stall_count_o port.
module forwarding_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs_id_i,
  input  logic [REG_BITS-1:0] rt_id_i,
  input  logic                rs_used_id_i,
  input  logic                rt_used_id_i,
  input  logic                reg_write_id_i,
  input  logic                mem_read_id_i,
  input  logic [REG_BITS-1:0] write_reg_id_i,
  input  logic                flush_i,
  output logic [1:0]          forward_a_o,
  output logic [1:0]          forward_b_o,
  output logic                stall_o
`ifdef FWD_STALL_COUNTER_EN
  ,
  output logic [CNT_BITS-1:0] stall_count_o
`endif
);

  if (CNT_BITS < 1 || REG_BITS < 1) begin : g_bad_param
    $error("REG_BITS and CNT_BITS must be at least 1");
  end

  logic                r_ex_valid;
  logic                r_ex_rw;
  logic                r_ex_load;
  logic [REG_BITS-1:0] r_ex_dest;
  logic [REG_BITS-1:0] r_ex_rs;
  logic [REG_BITS-1:0] r_ex_rt;
  logic                r_ex_rs_used;
  logic                r_ex_rt_used;

  logic                r_mem_valid;
  logic                r_mem_rw;
  logic                r_mem_load;
  logic [REG_BITS-1:0] r_mem_dest;

  logic                r_wb_valid;
  logic                r_wb_rw;
  logic                r_wb_load;
  logic [REG_BITS-1:0] r_wb_dest;

  logic w_mem_ok;
  logic w_wb_ok;
  logic w_stall;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_issue;

  // A load in MEM has no result yet, so only ALU producers forward from MEM.
  assign w_mem_ok = r_mem_valid && r_mem_rw && !r_mem_load
                    && (r_mem_dest != '0);
  assign w_wb_ok  = r_wb_valid && r_wb_rw && (r_wb_dest != '0);

  always_comb begin
    forward_a_o = 2'b00;
    if (w_mem_ok && r_ex_rs_used && (r_mem_dest == r_ex_rs))
      forward_a_o = 2'b01;
    else if (w_wb_ok && r_ex_rs_used && (r_wb_dest == r_ex_rs))
      forward_a_o = 2'b10;
  end

  always_comb begin
    forward_b_o = 2'b00;
    if (w_mem_ok && r_ex_rt_used && (r_mem_dest == r_ex_rt))
      forward_b_o = 2'b01;
    else if (w_wb_ok && r_ex_rt_used && (r_wb_dest == r_ex_rt))
      forward_b_o = 2'b10;
  end

  assign w_rs_hit = rs_used_id_i && (rs_id_i == r_ex_dest);
  assign w_rt_hit = rt_used_id_i && (rt_id_i == r_ex_dest);
  assign w_stall  = r_ex_valid && r_ex_load && (r_ex_dest != '0)
                    && (w_rs_hit || w_rt_hit);
  assign stall_o  = w_stall;
  assign w_issue  = !w_stall && !flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_rw      <= 1'b0;
      r_ex_load    <= 1'b0;
      r_ex_dest    <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rs_used <= 1'b0;
      r_ex_rt_used <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_load   <= 1'b0;
      r_mem_dest   <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rw      <= 1'b0;
      r_wb_load    <= 1'b0;
      r_wb_dest    <= '0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_rw     <= r_mem_rw;
      r_wb_load   <= r_mem_load;
      r_wb_dest   <= r_mem_dest;
      r_mem_valid <= r_ex_valid;
      r_mem_rw    <= r_ex_rw;
      r_mem_load  <= r_ex_load;
      r_mem_dest  <= r_ex_dest;
      if (w_issue) begin
        r_ex_valid   <= 1'b1;
        r_ex_rw      <= reg_write_id_i;
        r_ex_load    <= mem_read_id_i;
        r_ex_dest    <= write_reg_id_i;
        r_ex_rs      <= rs_id_i;
        r_ex_rt      <= rt_id_i;
        r_ex_rs_used <= rs_used_id_i;
        r_ex_rt_used <= rt_used_id_i;
      end else begin
        r_ex_valid   <= 1'b0;
        r_ex_rw      <= 1'b0;
        r_ex_load    <= 1'b0;
        r_ex_dest    <= '0;
        r_ex_rs      <= '0;
        r_ex_rt      <= '0;
        r_ex_rs_used <= 1'b0;
        r_ex_rt_used <= 1'b0;
      end
    end
  end

`ifdef FWD_STALL_COUNTER_EN
  logic [CNT_BITS-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
  end

  assign stall_count_o = r_stall_cnt;
`else
  logic w_wb_load_unused;
  assign w_wb_load_unused = r_wb_load;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed scoreboard bench for forwarding_hazard_unit.
// Define FWD_STALL_COUNTER_EN to also check stall_count_o.
module tb_forwarding_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] rs_id_i;
  logic [4:0] rt_id_i;
  logic       rs_used_id_i;
  logic       rt_used_id_i;
  logic       reg_write_id_i;
  logic       mem_read_id_i;
  logic [4:0] write_reg_id_i;
  logic       flush_i;
  logic [1:0] forward_a_o;
  logic [1:0] forward_b_o;
  logic       stall_o;
`ifdef FWD_STALL_COUNTER_EN
  logic [15:0] stall_count_o;
`endif

  forwarding_hazard_unit #(.REG_BITS(5), .CNT_BITS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .rs_id_i        (rs_id_i),
    .rt_id_i        (rt_id_i),
    .rs_used_id_i   (rs_used_id_i),
    .rt_used_id_i   (rt_used_id_i),
    .reg_write_id_i (reg_write_id_i),
    .mem_read_id_i  (mem_read_id_i),
    .write_reg_id_i (write_reg_id_i),
    .flush_i        (flush_i),
    .forward_a_o    (forward_a_o),
    .forward_b_o    (forward_b_o),
    .stall_o        (stall_o)
`ifdef FWD_STALL_COUNTER_EN
    ,
    .stall_count_o  (stall_count_o)
`endif
  );

  typedef struct {
    int          cyc;
    logic        chk;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic rst, input logic fl,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic rsu, input logic rtu,
    input logic rw, input logic mr, input logic [4:0] wd,
    input logic chk, input logic [1:0] fa, input logic [1:0] fb,
    input logic st, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    flush_i        = fl;
    rs_id_i        = rs;
    rt_id_i        = rt;
    rs_used_id_i   = rsu;
    rt_used_id_i   = rtu;
    reg_write_id_i = rw;
    mem_read_id_i  = mr;
    write_reg_id_i = wd;
    e.cyc = cyc;
    e.chk = chk;
    e.fa  = fa;
    e.fb  = fb;
    e.st  = st;
    e.cnt = cnt;
    q.push_back(e);
    cyc++;
  endtask

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          if (forward_a_o !== e.fa) begin
            errors++;
            $display("FAIL fa c%0d: got %b want %b", e.cyc, forward_a_o, e.fa);
          end
          checks++;
          if (forward_b_o !== e.fb) begin
            errors++;
            $display("FAIL fb c%0d: got %b want %b", e.cyc, forward_b_o, e.fb);
          end
          checks++;
          if (stall_o !== e.st) begin
            errors++;
            $display("FAIL stall c%0d: got %b want %b", e.cyc, stall_o, e.st);
          end
`ifdef FWD_STALL_COUNTER_EN
          checks++;
          if (stall_count_o !== e.cnt) begin
            errors++;
            $display("FAIL cnt c%0d: got %0d want %0d", e.cyc, stall_count_o, e.cnt);
          end
`endif
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; flush_i = 1'b0;
    rs_id_i = '0; rt_id_i = '0; rs_used_id_i = 1'b0; rt_used_id_i = 1'b0;
    reg_write_id_i = 1'b0; mem_read_id_i = 1'b0; write_reg_id_i = '0;
    //   rst fl rs  rt  su tu rw mr wd   chk fa     fb     st cnt
    step(1, 0, 0,  0,  0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0); // c0
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0); // c1
    // EX/MEM forward on rs
    step(0, 0, 1,  2,  1, 1, 1, 0, 3,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 3,  5,  1, 1, 1, 0, 4,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b01, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    // MEM/WB forward on rt
    step(0, 0, 0,  0,  0, 0, 1, 0, 3,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 8,  3,  1, 1, 1, 0, 9,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b10, 0, 0);
    // MEM wins over WB
    step(0, 0, 0,  0,  0, 0, 1, 0, 3,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 1, 0, 3,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 3,  0,  1, 0, 1, 0, 10, 1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b01, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    // load-use: one stall then WB forward
    step(0, 0, 1,  0,  1, 0, 1, 1, 2,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 2,  7,  1, 1, 1, 0, 6,  1, 2'b00, 2'b00, 1, 0);
    step(0, 0, 2,  7,  1, 1, 1, 0, 6,  1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b10, 2'b00, 0, 1);
    // register $0 never forwards or stalls
    step(0, 0, 0,  0,  0, 0, 1, 0, 0,  1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  1, 1, 1, 0, 11, 1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  0, 0, 1, 1, 0,  1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  1, 1, 1, 0, 12, 1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 1);
    // flush together with stall: single bubble
    step(0, 0, 0,  0,  0, 0, 1, 1, 5,  1, 2'b00, 2'b00, 0, 1);
    step(0, 1, 5,  5,  1, 1, 1, 0, 13, 1, 2'b00, 2'b00, 1, 1);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 2);
    // flushed producer must not forward
    step(0, 1, 0,  0,  0, 0, 1, 0, 14, 1, 2'b00, 2'b00, 0, 2);
    step(0, 0, 14, 0,  1, 0, 1, 0, 15, 1, 2'b00, 2'b00, 0, 2);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 2);
    // reset in the middle of a stall
    step(0, 0, 0,  0,  0, 0, 1, 1, 4,  1, 2'b00, 2'b00, 0, 2);
    step(1, 0, 4,  0,  1, 0, 1, 0, 15, 1, 2'b00, 2'b00, 1, 2);
    step(0, 0, 4,  0,  1, 0, 1, 0, 15, 1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    // three load-use stalls then reset
    step(0, 0, 0,  0,  0, 0, 1, 1, 2,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 1, 0);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 0, 1);
    step(0, 0, 0,  0,  0, 0, 1, 1, 2,  1, 2'b10, 2'b00, 0, 1);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 1, 1);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 0, 2);
    step(0, 0, 0,  0,  0, 0, 1, 1, 2,  1, 2'b10, 2'b00, 0, 2);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 1, 2);
    step(0, 0, 2,  0,  1, 0, 1, 0, 16, 1, 2'b00, 2'b00, 0, 3);
    step(1, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b10, 2'b00, 0, 3);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    step(0, 0, 0,  0,  0, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
